// File: rtl/lca_pkg.sv
// Shared types for list_call_arbiter: session state encoding.
package lca_pkg;

    localparam int LCA_STATE_W = 2;

    typedef enum logic [LCA_STATE_W-1:0] {
        IDLE    = 2'd0,
        CALL    = 2'd1,
        STREAM  = 2'd2,
        RELEASE = 2'd3
    } lca_state_t;

endpackage

// File: rtl/lca_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module lca_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!any && req[pos]) begin
                any         = 1'b1;
                onehot[pos] = 1'b1;
                idx         = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/list_call_arbiter.sv
// Round-robin session arbiter sharing one call/lazy-list function between N_REQ clients.
// Optional stall watchdog enabled by defining LCA_WATCHDOG_EN.
module list_call_arbiter
    import lca_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int ARG_W       = 8,
    parameter int DATA_W      = 8,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         cl_call,
    input  logic [N_REQ*ARG_W-1:0]   cl_arg0,
    input  logic [N_REQ*ARG_W-1:0]   cl_arg1,
    input  logic [N_REQ-1:0]         cl_req,
    output logic [N_REQ-1:0]         cl_grant,
    output logic [N_REQ-1:0]         cl_done,
    output logic [N_REQ-1:0]         cl_ack,
    output logic [DATA_W-1:0]        cl_value,
    output logic                     cl_value_valid,
    output logic                     fn_ready,
    output logic [ARG_W-1:0]         fn_arg0,
    output logic [ARG_W-1:0]         fn_arg1,
    output logic                     fn_req,
    input  logic                     fn_done,
    input  logic                     fn_ack,
    input  logic [DATA_W-1:0]        fn_value,
    input  logic                     fn_value_valid,
    output logic                     busy,
    output logic                     abort
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    lca_state_t       state, state_nxt;
    logic [IDX_W-1:0] owner, ptr;
    logic             drain, drain_nxt;
    logic             stream_req;
    logic             wd_hit;

    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    lca_rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (cl_call),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Once the owner abandons a pending request, the request is held until the
    // function acknowledges it so the function never sees a half-finished handshake.
    assign stream_req = drain | cl_req[owner];
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt      = state;
        drain_nxt      = drain;
        fn_ready       = 1'b0;
        fn_req         = 1'b0;
        cl_done        = '0;
        cl_ack         = '0;
        cl_value       = '0;
        cl_value_valid = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any)
                    state_nxt = CALL;
            end
            CALL: begin
                fn_ready       = 1'b1;
                cl_done[owner] = fn_done;
                if (!cl_call[owner])
                    state_nxt = RELEASE;
                else if (fn_done)
                    state_nxt = STREAM;
            end
            STREAM: begin
                fn_ready       = 1'b1;
                fn_req         = stream_req;
                cl_value       = fn_value;
                cl_value_valid = fn_value_valid;
                if (!drain)
                    cl_ack[owner] = fn_ack;
                if (drain) begin
                    if (fn_ack)
                        state_nxt = RELEASE;
                end else if (!cl_call[owner]) begin
                    if (stream_req && !fn_ack)
                        drain_nxt = 1'b1;
                    else
                        state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A watchdog abort looks to the owner like an end-of-list element.
        if (wd_hit) begin
            cl_ack         = cl_grant;
            cl_value_valid = 1'b0;
            state_nxt      = RELEASE;
        end
        if (state_nxt != STREAM)
            drain_nxt = 1'b0;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            drain    <= 1'b0;
            ptr      <= '0;
            owner    <= '0;
            cl_grant <= '0;
            fn_arg0  <= '0;
            fn_arg1  <= '0;
        end else begin
            state <= state_nxt;
            drain <= drain_nxt;
            if (state == IDLE && pick_any) begin
                cl_grant <= pick_oh;
                owner    <= pick_idx;
                fn_arg0  <= cl_arg0[pick_idx*ARG_W +: ARG_W];
                fn_arg1  <= cl_arg1[pick_idx*ARG_W +: ARG_W];
                ptr      <= (pick_idx == IDX_W'(N_REQ-1)) ? '0 : pick_idx + IDX_W'(1);
            end else if (state_nxt == RELEASE) begin
                cl_grant <= '0;
            end
        end
    end

`ifdef LCA_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES+1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_run;

    assign wd_run = (state == CALL) || (state == STREAM && stream_req);
    // The WDOG_CYCLES-th consecutive stalled cycle is the abort cycle.
    assign wd_hit = wd_run && !fn_done && !fn_ack && (wd_cnt == WD_W'(WDOG_CYCLES-1));
    assign abort  = wd_hit;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            wd_cnt <= '0;
        else if (state_nxt != state || fn_done || fn_ack)
            wd_cnt <= '0;
        else if (wd_run)
            wd_cnt <= wd_cnt + WD_W'(1);
    end
`else
    // Never true for a legal WDOG_CYCLES: without the watchdog the arbiter waits forever.
    assign wd_hit = (WDOG_CYCLES < 0);
    assign abort  = 1'b0;
`endif

endmodule

// File: tb/tb_list_call_arbiter.sv
// Randomized self-checking bench for list_call_arbiter with an abstract session-level model.
module tb_list_call_arbiter;

    localparam int N      = 3;
    localparam int ARG_W  = 8;
    localparam int DATA_W = 8;
    localparam int WDOG   = 16;

    logic                 clk, reset;
    logic [N-1:0]         cl_call, cl_req;
    logic [N*ARG_W-1:0]   cl_arg0, cl_arg1;
    logic [N-1:0]         cl_grant, cl_done, cl_ack;
    logic [DATA_W-1:0]    cl_value;
    logic                 cl_value_valid;
    logic                 fn_ready, fn_req;
    logic [ARG_W-1:0]     fn_arg0, fn_arg1;
    logic                 fn_done, fn_ack;
    logic [DATA_W-1:0]    fn_value;
    logic                 fn_value_valid;
    logic                 busy, abort;

    int n_tests = 0;
    int n_fail  = 0;
    int ptr_m   = 0;
    logic [ARG_W-1:0] a0_m [N];
    logic [ARG_W-1:0] a1_m [N];

    list_call_arbiter #(
        .N_REQ(N), .ARG_W(ARG_W), .DATA_W(DATA_W), .WDOG_CYCLES(WDOG)
    ) dut (
        .CLOCK_50(clk), .reset(reset),
        .cl_call(cl_call), .cl_arg0(cl_arg0), .cl_arg1(cl_arg1), .cl_req(cl_req),
        .cl_grant(cl_grant), .cl_done(cl_done), .cl_ack(cl_ack),
        .cl_value(cl_value), .cl_value_valid(cl_value_valid),
        .fn_ready(fn_ready), .fn_arg0(fn_arg0), .fn_arg1(fn_arg1), .fn_req(fn_req),
        .fn_done(fn_done), .fn_ack(fn_ack), .fn_value(fn_value),
        .fn_value_valid(fn_value_valid), .busy(busy), .abort(abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural round-robin: first caller at or after the pointer, wrapping.
    function automatic int rr_model(input logic [N-1:0] pend, input int p);
        for (int k = 0; k < N; k++)
            if (pend[(p+k)%N]) return (p+k)%N;
        return -1;
    endfunction

    task automatic set_args(input int i, input logic [ARG_W-1:0] x0, input logic [ARG_W-1:0] x1);
        a0_m[i] = x0;
        a1_m[i] = x1;
        cl_arg0[i*ARG_W +: ARG_W] = x0;
        cl_arg1[i*ARG_W +: ARG_W] = x1;
    endtask

    task automatic rand_other(input int own);
        logic [N-1:0] r;
        int o;
        r = N'($urandom);
        r[own] = cl_req[own];
        cl_req = r;
        o = $urandom_range(0, N-1);
        if (o != own) set_args(o, ARG_W'($urandom), ARG_W'($urandom));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cl_call = '0; cl_req = '0;
        fn_done = 1'b0; fn_ack = 1'b0; fn_value = '0; fn_value_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        ptr_m = 0;
    endtask

    task automatic wait_grant();
        int t;
        t = 0;
        while (cl_grant == '0 && t < 20) begin
            @(negedge clk); #1;
            t++;
        end
    endtask

    // Full session for the expected owner: grant, call, nelem elements + end of list, drop.
    task automatic serve(input int own, input int nelem, input bit recall);
        logic [ARG_W-1:0]  la0, la1;
        logic [N-1:0]      oh;
        logic [DATA_W-1:0] v;
        int                stall;
        oh = '0; oh[own] = 1'b1;
        wait_grant();
        chk("grant", cl_grant, oh);
        la0 = a0_m[own]; la1 = a1_m[own];
        chk("arg0", fn_arg0, la0);
        chk("arg1", fn_arg1, la1);
        chk("busy", busy, 1);
        ptr_m = (own + 1) % N;
        set_args(own, ARG_W'($urandom), ARG_W'($urandom));
        repeat ($urandom_range(0, 2)) begin
            chk("call_ready", fn_ready, 1);
            chk("call_done_idle", cl_done, 0);
            @(negedge clk); #1;
        end
        fn_done = 1'b1; #1;
        chk("done_route", cl_done, oh);
        @(negedge clk);
        fn_done = 1'b0;
        for (int k = 0; k <= nelem; k++) begin
            cl_req = '0; cl_req[own] = 1'b1;
            stall = $urandom_range(0, 2);
            for (int s = 0; s < stall; s++) begin
                rand_other(own); #1;
                chk("req_fwd", fn_req, 1);
                chk("ack_idle", cl_ack, 0);
                @(negedge clk);
            end
            rand_other(own);
            v = DATA_W'($urandom);
            fn_value = v; fn_value_valid = (k < nelem); fn_ack = 1'b1; #1;
            chk("ack_route", cl_ack, oh);
            chk("value", cl_value, v);
            chk("value_valid", cl_value_valid, (k < nelem));
            @(negedge clk);
            fn_ack = 1'b0; fn_value_valid = 1'b0;
            cl_req[own] = 1'b0; rand_other(own); #1;
            chk("req_iso", fn_req, 0);
            chk("ack_iso", cl_ack, 0);
            @(negedge clk);
        end
        cl_req = '0; cl_call[own] = 1'b0; #1;
        chk("arg0_hold", fn_arg0, la0);
        chk("arg1_hold", fn_arg1, la1);
        @(negedge clk);
        if (recall) cl_call[own] = 1'b1;
        #1;
        chk("rel_ready", fn_ready, 0);
        chk("rel_grant", cl_grant, 0);
        chk("rel_busy", busy, 1);
        @(negedge clk); #1;
        chk("idle_busy", busy, 0);
        if (recall) begin
            @(negedge clk); #1;
            chk("recall_grant", cl_grant, oh);
        end
    endtask

    task automatic open_session(input int own);
        logic [N-1:0] oh;
        oh = '0; oh[own] = 1'b1;
        wait_grant();
        chk("os_grant", cl_grant, oh);
        ptr_m = (own + 1) % N;
        fn_done = 1'b1;
        @(negedge clk);
        fn_done = 1'b0;
    endtask

    task automatic early_release(input int own);
        open_session(own);
        cl_req[own] = 1'b1; #1;
        chk("er_req", fn_req, 1);
        @(negedge clk);
        cl_call[own] = 1'b0; #1;
        chk("er_req_drop", fn_req, 1);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            cl_req = '0;
            if (s == 4) begin fn_ack = 1'b1; fn_value_valid = 1'b1; end
            #1;
            chk("er_hold", fn_req, 1);
            chk("er_swallow", cl_ack, 0);
        end
        @(negedge clk);
        fn_ack = 1'b0; fn_value_valid = 1'b0; #1;
        chk("er_rel_ready", fn_ready, 0);
        chk("er_rel_req", fn_req, 0);
        chk("er_rel_grant", cl_grant, 0);
        @(negedge clk); #1;
        chk("er_idle", busy, 0);
    endtask

    initial begin
        int w, ab, hit;
        cl_arg0 = '0; cl_arg1 = '0;
        for (int i = 0; i < N; i++) set_args(i, '0, '0);
        do_reset();
        #1;
        chk("rst_grant", cl_grant, 0);
        chk("rst_ready", fn_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_arg0", fn_arg0, 0);
        chk("rst_abort", abort, 0);

        // Lone call with re-call latency
        @(negedge clk);
        set_args(0, 8'd1, 8'd2);
        cl_call = 3'b001;
        serve(0, 3, 1'b1);
        serve(0, 1, 1'b0);

        // Contention from reset pointer: order 0,1,0,1
        do_reset();
        set_args(0, 8'h10, 8'h20);
        set_args(1, 8'h11, 8'h21);
        cl_call = 3'b011;
        serve(rr_model(cl_call, ptr_m), 2, 1'b0);
        chk("rr_ptr1", ptr_m, 1);
        cl_call[0] = 1'b1;
        serve(1, 1, 1'b0);
        cl_call[1] = 1'b1;
        serve(0, 0, 1'b0);
        serve(1, 2, 1'b0);

        // Early release with pending request
        @(negedge clk);
        cl_call = 3'b010;
        early_release(1);

        // Async reset mid-stream, then pointer back at client 0
        @(negedge clk);
        cl_call = 3'b001;
        open_session(0);
        cl_req[0] = 1'b1; fn_ack = 1'b1; fn_value = 8'hA5; fn_value_valid = 1'b1; #1;
        chk("pre_rst_ack", cl_ack, 3'b001);
        #1 reset = 1'b1;
        #1;
        chk("arst_grant", cl_grant, 0);
        chk("arst_ready", fn_ready, 0);
        chk("arst_ack", cl_ack, 0);
        chk("arst_req", fn_req, 0);
        chk("arst_value", cl_value, 0);
        chk("arst_busy", busy, 0);
        chk("arst_arg0", fn_arg0, 0);
        @(negedge clk);
        reset = 1'b0; ptr_m = 0;
        fn_ack = 1'b0; fn_value_valid = 1'b0; cl_req = '0;
        cl_call = 3'b011;
        serve(0, 1, 1'b0);
        serve(1, 0, 1'b0);

        // Randomized sessions against the round-robin model
        repeat (25) begin
            for (int i = 0; i < N; i++)
                if (!cl_call[i] && $urandom_range(0, 1) == 1) begin
                    set_args(i, ARG_W'($urandom), ARG_W'($urandom));
                    cl_call[i] = 1'b1;
                end
            if (cl_call == '0) cl_call[$urandom_range(0, N-1)] = 1'b1;
            w = rr_model(cl_call, ptr_m);
            serve(w, $urandom_range(0, 4), 1'b0);
        end

        // Stalled function: watchdog abort or indefinite wait
        @(negedge clk);
        cl_call = 3'b001;
        open_session(0);
        cl_req[0] = 1'b1;
`ifdef LCA_WATCHDOG_EN
        hit = 0;
        for (int c = 1; c <= 40 && hit == 0; c++) begin
            #1;
            if (abort) begin
                hit = c;
                chk("wd_ack", cl_ack, 3'b001);
                chk("wd_valid", cl_value_valid, 0);
            end
            @(negedge clk);
        end
        chk("wd_cycle", hit, WDOG);
        #1;
        chk("wd_release", fn_ready, 0);
        chk("wd_abort_pulse", abort, 0);
        cl_call = '0; cl_req = '0;
`else
        ab = 0;
        hit = 0;
        for (int c = 0; c < 1000; c++) begin
            #1;
            if (abort) ab++;
            if (cl_ack != '0) hit++;
            @(negedge clk);
        end
        #1;
        chk("nowd_abort", ab, 0);
        chk("nowd_ack", hit, 0);
        chk("nowd_busy", busy, 1);
        chk("nowd_ready", fn_ready, 1);
        chk("nowd_req", fn_req, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
